// File: rtl/blink_rate_ctrl.sv
// Button-driven blink-rate selector for the LED blinker: synchronizes and debounces BTN,
// cycles through four rates per debounced press and emits a one-cycle TICK at the selected period.
module blink_rate_ctrl #(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int PERIOD0         = 27_000_000,
    parameter int PERIOD1         = 13_500_000,
    parameter int PERIOD2         = 6_750_000,
    parameter int PERIOD3         = 2_700_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       TICK,
    output logic       PRESS,
    output logic [1:0] RATE_SEL
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic RELEASED = (BTN_ACTIVE_LOW != 0);
    localparam int PERIODS [4] = '{PERIOD0, PERIOD1, PERIOD2, PERIOD3};

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    logic [1:0]      sync_reg;
    logic            btn_pressed;
    db_state_t       state_reg, state_next;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            press_next;
    logic            press_reg;
    logic            tick_reg;
    logic [1:0]      rate_reg;
    logic [24:0]     period_cnt_reg;
    logic [24:0]     limit_tab [4];
    logic [24:0]     period_limit;

    // Terminal counts, one per rate index.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_limit
            assign limit_tab[gi] = 25'(PERIODS[gi] - 1);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg <= {RELEASED, RELEASED};
        end else begin
            sync_reg <= {sync_reg[0], BTN};
        end
    end

    assign btn_pressed = sync_reg[1] ^ RELEASED;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            db_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            db_cnt_reg <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        db_cnt_next = db_cnt_reg;
        press_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_pressed) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_pressed) begin
                    state_next = IDLE;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next = HELD;
                    press_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            HELD: begin
                if (!btn_pressed) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed returns to HELD without a new press.
                if (btn_pressed) begin
                    state_next = HELD;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign period_limit = limit_tab[rate_reg];

    // A press restarts the period so the first tick at the new rate is a full period away.
    always_ff @(posedge CLK) begin
        if (RST) begin
            press_reg      <= 1'b0;
            rate_reg       <= 2'd0;
            period_cnt_reg <= '0;
            tick_reg       <= 1'b0;
        end else begin
            press_reg <= press_next;
            if (press_next) begin
                rate_reg       <= rate_reg + 2'd1;
                period_cnt_reg <= '0;
                tick_reg       <= 1'b0;
            end else if (period_cnt_reg == period_limit) begin
                period_cnt_reg <= '0;
                tick_reg       <= 1'b1;
            end else begin
                period_cnt_reg <= period_cnt_reg + 25'd1;
                tick_reg       <= 1'b0;
            end
        end
    end

    assign TICK     = tick_reg;
    assign PRESS    = press_reg;
    assign RATE_SEL = rate_reg;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Self-checking bench for blink_rate_ctrl: directed phases plus random button activity,
// compared each cycle against an event-level model of debounce, rate stepping and tick timing.
module tb_blink_rate_ctrl;

    localparam int D = 4;
    localparam int P [4] = '{8, 6, 4, 2};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN = 1'b1;
    logic       TICK;
    logic       PRESS;
    logic [1:0] RATE_SEL;

    always #5 CLK = ~CLK;

    blink_rate_ctrl #(
        .BTN_ACTIVE_LOW (1),
        .DEBOUNCE_CYCLES(D),
        .PERIOD0        (P[0]),
        .PERIOD1        (P[1]),
        .PERIOD2        (P[2]),
        .PERIOD3        (P[3])
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTN     (BTN),
        .TICK    (TICK),
        .PRESS   (PRESS),
        .RATE_SEL(RATE_SEL)
    );

    int checks = 0;
    int errors = 0;

    // Model state: absolute cycle numbers and a run length of disagreeing samples.
    int cyc = 0;
    int m_sel = 0;
    int m_next_tick = 0;
    bit m_db = 1'b0;
    int m_run = 0;
    bit m_q[$];
    bit exp_tick;
    bit exp_press;

    int press_seen = 0;
    int last_press_cyc = 0;
    int tick_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit btn, input bit rst);
        bit p;
        BTN = btn;
        RST = rst;
        @(posedge CLK);
        cyc++;
        if (rst) begin
            m_q = {1'b0, 1'b0};
            m_db = 1'b0;
            m_run = 0;
            m_sel = 0;
            m_next_tick = cyc + P[0];
            exp_tick = 1'b0;
            exp_press = 1'b0;
        end else begin
            // Debounced level seen two samples late; it flips after D+1 consecutive disagreeing samples.
            p = m_q[0];
            void'(m_q.pop_front());
            m_q.push_back(btn == 1'b0);
            exp_press = 1'b0;
            if (p != m_db) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_db = p;
                m_run = 0;
                exp_press = p;
            end
            exp_tick = 1'b0;
            if (exp_press) begin
                m_sel = (m_sel + 1) % 4;
                m_next_tick = cyc + P[m_sel];
            end else if (cyc == m_next_tick) begin
                exp_tick = 1'b1;
                m_next_tick = cyc + P[m_sel];
            end
        end
        #1;
        check("tick", TICK, exp_tick);
        check("press", PRESS, exp_press);
        check("rate_sel", RATE_SEL, m_sel);
        if (PRESS === 1'b1) begin
            press_seen++;
            last_press_cyc = cyc;
            $display("cycle %0d: press, rate_sel=%0d", cyc, RATE_SEL);
        end
        if (TICK === 1'b1) tick_seen++;
    endtask

    initial begin
        int r;
        int first_tick;
        int c0;
        int lvl;
        int len;
        int tries;
        logic [1:0] sel_after [4];
        sel_after[0] = 2'd2;
        sel_after[1] = 2'd3;
        sel_after[2] = 2'd0;
        sel_after[3] = 2'd1;

        // Reset and idle
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("reset_rate_sel", RATE_SEL, 0);
        check("reset_tick", TICK, 0);
        check("reset_press", PRESS, 0);
        r = cyc;
        first_tick = -1;
        tick_seen = 0;
        press_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            if (TICK === 1'b1 && first_tick < 0) first_tick = cyc - r;
        end
        check("first_tick_delay", first_tick, 8);
        check("idle_tick_count", tick_seen, 5);
        check("idle_press_count", press_seen, 0);

        // Long clean press
        press_seen = 0;
        c0 = cyc + 1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        check("held_press_count", press_seen, 1);
        check("press_latency", last_press_cyc - c0, 6);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        // Short glitch
        press_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        check("glitch_press_count", press_seen, 0);

        // Four clean presses
        for (int k = 0; k < 4; k++) begin
            press_seen = 0;
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
            check("clean_press_count", press_seen, 1);
            check("clean_rate_sel", RATE_SEL, sel_after[k]);
        end

        // Release bounce
        press_seen = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(((i / 2) % 2) == 0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        check("bounce_press_count", press_seen, 1);

        // Random bursty button activity with rare resets
        for (int i = 0; i < 300; ) begin
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                step(lvl[0], ($urandom_range(0, 149) == 0));
                i++;
            end
        end

        // Reset mid-debounce at rate 2
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        tries = 0;
        while (m_sel != 2 && tries < 6) begin
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
            tries++;
        end
        check("pre_reset_rate_sel", RATE_SEL, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("midrst_rate_sel", RATE_SEL, 0);
        check("midrst_tick", TICK, 0);
        check("midrst_press", PRESS, 0);
        press_seen = 0;
        c0 = cyc + 1;
        for (int i = 0; i < 20 && press_seen == 0; i++) step(1'b0, 1'b0);
        check("post_rst_press_count", press_seen, 1);
        check("post_rst_press_latency", last_press_cyc - c0, 6);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
